// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings, field limits, key indices and wrap helper
package clock_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_MIN = 2'd1, SET_SEC = 2'd2, COMMIT = 2'd3} mode_t;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam int KEY_MODE = 0;
  localparam int KEY_INC = 1;
  localparam int KEY_DEC = 2;
  localparam int KEY_CLR = 3;
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic up, input logic [5:0] max);
    return up ? (v == max ? 6'd0 : v + 6'd1) : (v == 6'd0 ? max : v - 6'd1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes one active-low key, debounces it and pulses on press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_50,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, db, db_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_50) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      db <= 1'b1;
      db_d <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      db_d <= db;
      press <= db_d & ~db;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven minutes:seconds edit FSM with hold/load control
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       run_en,
  output logic [1:0] mode,
  output logic       blink
);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [3:0] p;
  mode_t state, next;
  logic editing, next_edit, act_edit;
  logic [5:0] edit_val;
  logic [BW-1:0] bcnt;
  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_50(clk_50),
      .rst(rst),
      .key_n(key_n[g]),
      .press(p[g])
    );
  end
  always_ff @(posedge clk_50) state <= rst ? RUN : next;
  always_comb begin
    next = state == RUN ? (p[KEY_MODE] ? SET_MIN : RUN) :
           state == COMMIT ? RUN :
           p[KEY_MODE] ? (state == SET_MIN ? SET_SEC : COMMIT) : state;
  end
  always_comb begin
    run_en = state == RUN;
    load = state == COMMIT;
    mode = state;
  end
  // Mode wins; clear beats inc/dec; inc together with dec cancels out.
  assign editing = state == SET_MIN || state == SET_SEC;
  assign next_edit = next == SET_MIN || next == SET_SEC;
  assign act_edit = editing && !p[KEY_MODE] && (p[KEY_CLR] || (p[KEY_INC] ^ p[KEY_DEC]));
  assign edit_val = p[KEY_CLR] ? 6'd0 :
                    state == SET_MIN ? wrap_step(set_min, p[KEY_INC], MAX_MIN) :
                    wrap_step(set_sec, p[KEY_INC], MAX_SEC);
  always_ff @(posedge clk_50) begin
    if (rst) begin
      set_min <= 6'd0;
      set_sec <= 6'd0;
    end else if (state == RUN && p[KEY_MODE]) begin
      set_min <= cur_min;
      set_sec <= cur_sec;
    end else if (act_edit && state == SET_MIN) set_min <= edit_val;
    else if (act_edit) set_sec <= edit_val;
  end
  // Blink restarts visible whenever a field is entered or changed.
  always_ff @(posedge clk_50) begin
    if (rst || !next_edit) begin
      blink <= 1'b0;
      bcnt <= '0;
    end else if (next != state || act_edit) begin
      blink <= 1'b1;
      bcnt <= '0;
    end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
      blink <= ~blink;
      bcnt <= '0;
    end else bcnt <= bcnt + 1'b1;
  end
endmodule
